// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding and the stream framing constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam int HDR_LEN        = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Packs accepted bytes big-endian into 32-bit words; word_vld pulses one cycle after the 4th byte.
// Consumes only byte_acc strobes from its parent, so it never throttles the byte stream itself.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_acc,
   input  logic [7:0]  byte_dat,
   output logic        word_vld,
   output logic [31:0] word_dat
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      sh_q, sh_d;
   logic             vld_q, vld_d;

   always_comb begin
      idx_d = idx_q;
      sh_d  = sh_q;
      vld_d = 1'b0;
      if (clr) begin
         idx_d = '0;
      end else if (byte_acc) begin
         sh_d  = {sh_q[23:0], byte_dat};
         idx_d = idx_q + IDX_W'(1);
         vld_d = (idx_q == LAST_IDX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         sh_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         sh_q  <= sh_d;
         vld_q <= vld_d;
      end
   end

   assign word_vld = vld_q;
   assign word_dat = sh_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into instruction-memory writes.
// One write per 4 accepted bytes, issued the cycle after the last byte; byte_ready drops while the final word lands.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MAX_WORDS = 64,
   parameter int ADDR_W    = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] wc_q, wc_d;
   logic [7:0]  csum_q, csum_d;
   logic        clr, acc, data_acc, last_pend;
   logic        word_vld;
   logic [31:0] word_dat;
   logic [15:0] n_full;

   assign acc       = byte_valid && byte_ready;
   assign data_acc  = acc && (state_q == ST_DATA);
   assign n_full    = {n_q[15:8], byte_data};
   // The checksum byte must not be swallowed as payload while the final write is still pending.
   assign last_pend = word_vld && ((wc_q + 16'd1) == n_q);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      wc_d       = wc_q;
      csum_d     = csum_q;
      clr        = 1'b0;
      byte_ready = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d = ST_LEN_HI;
               wc_d    = '0;
               csum_d  = '0;
               clr     = 1'b1;
            end
         end
         ST_LEN_HI: begin
            byte_ready = 1'b1;
            if (acc) begin
               n_d[15:8] = byte_data;
               csum_d    = csum_q ^ byte_data;
               state_d   = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            byte_ready = 1'b1;
            if (acc) begin
               n_d    = n_full;
               csum_d = csum_q ^ byte_data;
               if (n_full == 16'd0)               state_d = ST_CHECK;
               else if ({1'b0, n_full} > MAX_N)   state_d = ST_ERROR;
               else                               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            byte_ready = !last_pend;
            if (acc) csum_d = csum_q ^ byte_data;
            if (word_vld) begin
               wc_d = wc_q + 16'd1;
               if (last_pend) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            byte_ready = 1'b1;
            if (acc) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         wc_q    <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wc_q    <= wc_d;
         csum_q  <= csum_d;
      end
   end

   word_assembler u_word_asm (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .byte_acc (data_acc),
      .byte_dat (byte_data),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   assign im_we      = word_vld;
   assign im_wdata   = word_vld ? word_dat : 32'd0;
   assign im_addr    = ADDR_W'({wc_q, 2'b00});
   assign cpu_hold   = (state_q != ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERROR);
   assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load streams checked against a transaction-level model of the loader.
module tb_imem_loader;

   localparam int MAXW = 64;

   logic        clk = 1'b0;
   logic        rst, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, im_we, cpu_hold, done, error;
   logic [31:0] im_addr, im_wdata;
   logic [15:0] word_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   logic [7:0]  strm[$];
   logic [31:0] words[$];
   bit          exp_ok;

   imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (im_we) begin
         got_addr.push_back(im_addr);
         got_data.push_back(im_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/byte_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "/im_we"},      32'(im_we),      32'd0);
      check({tag, "/im_addr"},    im_addr,         32'd0);
      check({tag, "/im_wdata"},   im_wdata,        32'd0);
      check({tag, "/cpu_hold"},   32'(cpu_hold),   32'd1);
      check({tag, "/done"},       32'(done),       32'd0);
      check({tag, "/error"},      32'(error),      32'd0);
      check({tag, "/word_count"}, 32'(word_count), 32'd0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Stream = len_hi, len_lo, payload (big-endian words), checksum; oversize loads stop after the header.
   task automatic build(input logic [15:0] n, input bit force_en, input logic [7:0] force_val);
      logic [7:0] x;
      logic [7:0] c;
      strm.delete();
      x = n[15:8] ^ n[7:0];
      strm.push_back(n[15:8]);
      strm.push_back(n[7:0]);
      exp_ok = 1'b0;
      if (n <= MAXW) begin
         for (int i = 0; i < int'(n); i++) begin
            for (int b = 3; b >= 0; b--) begin
               c = words[i][8*b +: 8];
               strm.push_back(c);
               x ^= c;
            end
         end
         c = force_en ? force_val : x;
         strm.push_back(c);
         exp_ok = (c == x);
      end
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   // mode 0: always valid, 1: valid every other cycle, 2: random valid
   task automatic drive(input int mode, input bit poke_start);
      int i;
      int cyc;
      i = 0;
      cyc = 0;
      while (i < strm.size() && cyc < 2000) begin
         byte_data  = strm[i];
         byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         start      = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         if (byte_valid && byte_ready) i++;
         @(posedge clk); #1;
         cyc++;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      if (i < strm.size()) check("stream_timeout", 32'(i), 32'(strm.size()));
   endtask

   task automatic verify(input string tag, input logic [15:0] n);
      int nexp;
      nexp = (n <= MAXW) ? int'(n) : 0;
      check({tag, "/nwrites"}, 32'(got_addr.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < got_addr.size(); i++) begin
         check({tag, "/addr"}, got_addr[i], 32'(4 * i));
         check({tag, "/data"}, got_data[i], words[i]);
      end
      check({tag, "/done"},       32'(done),       32'(exp_ok));
      check({tag, "/error"},      32'(error),      32'(!exp_ok));
      check({tag, "/cpu_hold"},   32'(cpu_hold),   32'(!exp_ok));
      check({tag, "/word_count"}, 32'(word_count), 32'(nexp));
   endtask

   task automatic run_load(input string tag, input logic [15:0] n, input int mode,
                           input bit poke, input bit force_en, input logic [7:0] force_val);
      got_addr.delete();
      got_data.delete();
      do_start();
      build(n, force_en, force_val);
      drive(mode, poke);
      verify(tag, n);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      words = '{32'h20080005, 32'hAC080000};
      run_load("two_words", 16'd2, 0, 1'b0, 1'b0, 8'h00);

      words = '{32'h20080005, 32'hAC080000};
      run_load("two_words_toggle", 16'd2, 1, 1'b0, 1'b0, 8'h00);

      words.delete();
      run_load("oversize", 16'h0041, 0, 1'b0, 1'b0, 8'h00);

      words = '{32'h00000000};
      run_load("bad_cks", 16'd1, 0, 1'b0, 1'b1, 8'hFF);

      words.delete();
      run_load("zero_len", 16'd0, 0, 1'b0, 1'b0, 8'h00);
      do_start();
      check("restart/done",       32'(done),       32'd0);
      check("restart/cpu_hold",   32'(cpu_hold),   32'd1);
      check("restart/byte_ready", 32'(byte_ready), 32'd1);
      check("restart/word_count", 32'(word_count), 32'd0);
      got_addr.delete();
      got_data.delete();
      build(16'd0, 1'b0, 8'h00);
      drive(0, 1'b0);
      verify("zero_len_again", 16'd0);

      rand_words(2);
      got_addr.delete();
      got_data.delete();
      do_start();
      build(16'd2, 1'b0, 8'h00);
      while (strm.size() > 8) void'(strm.pop_back());
      drive(0, 1'b0);
      check("pre_abort/nwrites", 32'(got_addr.size()), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort/no_late_write", 32'(got_addr.size()), 32'd1);
      rand_words(1);
      run_load("after_abort", 16'd1, 0, 1'b0, 1'b0, 8'h00);

      for (int t = 0; t < 24; t++) begin
         logic [15:0] n;
         n = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(MAXW + 1, MAXW + 8))
                                         : 16'($urandom_range(0, 5));
         rand_words((n <= MAXW) ? int'(n) : 0);
         run_load("random", n, $urandom_range(0, 2), 1'b1,
                  ($urandom_range(0, 3) == 0), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
